pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage core. It sequences the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers by driving their write-enables, flushes and bubble inserts. It resolves load-use hazards, taken-branch flushes in ID, and multi-cycle data-memory waits. A wait that does not complete enters a sticky fault state.

Parameters:
CNT_W, 16, width of the saturating stall-cycle counter
TMO_CYC, 255, maximum MEM_WAIT cycles before entering FAULT (1..2^TMO_W-1)
TMO_W, 8, width of the wait-timeout counter

Ports:
clk  in  1  clock; all state updates on posedge
rst_i  in  1  reset; asynchronous, active-high
start_i  in  1  leave IDLE and begin execution
id_rs1_addr_i  in  5  rs1 of the instruction in ID
id_rs2_addr_i  in  5  rs2 of the instruction in ID
id_uses_rs2_i  in  1  ID instruction reads rs2
ex_memread_i  in  1  instruction in EX is a load
ex_rd_addr_i  in  5  rd of the instruction in EX
branch_taken_i  in  1  branch resolved taken in ID
mem_req_i  in  1  MEM stage issues a data-memory access this cycle
mem_ack_i  in  1  data memory completes the access
pc_write_o  out  1  PC enable
ifid_write_o  out  1  IF/ID enable
ifid_flush_o  out  1  zero IF/ID instruction on next edge
idex_write_o  out  1  ID/EX enable
idex_bubble_o  out  1  zero ID/EX WB/M/ALU control fields on next edge
exmem_write_o  out  1  EX/MEM enable
memwb_bubble_o  out  1  zero MEM/WB WB control field on next edge
state_o  out  2  IDLE=0, RUN=1, MEM_WAIT=2, FAULT=3
stall_cnt_o  out  CNT_W  saturating count of stalled cycles
fault_o  out  1  memory-wait timeout occurred; sticky until reset

Behaviour:
- Async reset: state=IDLE, stall counter=0, timeout counter=0, fault_o=0. Outputs follow the IDLE decode below.
- Outputs are combinational from the registered state and the current inputs. State and counters are registered.
- IDLE: all *_write_o=0, idex_bubble_o=1, memwb_bubble_o=1, ifid_flush_o=0. If start_i=1, next state is RUN. start_i is ignored in all other states.
- RUN default: all *_write_o=1, all bubble and flush outputs 0.
- RUN priority, highest first:
  1. mem_req_i=1 and mem_ack_i=0: next state is MEM_WAIT. pc/ifid/idex/exmem writes=0, memwb_bubble_o=1. Timeout counter loads 1.
  2. Load-use hazard: ex_memread_i=1, ex_rd_addr_i!=0, and (rs1==rd or (id_uses_rs2_i and rs2==rd)). pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, idex/exmem writes stay 1. Lasts one cycle only; no state change.
  3. branch_taken_i=1 with no hazard: ifid_flush_o=1, pc_write_o=1. The branch is ignored while rule 1 or 2 applies, because ID holds and re-evaluates it.
- mem_req_i=1 with mem_ack_i=1 in RUN is a zero-wait access: no stall.
- MEM_WAIT: freeze outputs as in rule 1.
  - mem_ack_i=1: next state is RUN, timeout counter clears, and the current cycle's outputs are still the freeze outputs.
  - Otherwise the timeout counter increments. When it equals TMO_CYC with no ack, next state is FAULT.
  - A hazard or branch arriving during MEM_WAIT is not acted on.
- FAULT: outputs identical to IDLE, fault_o=1. Only rst_i exits FAULT.
- stall_cnt_o increments by 1 on every clock edge where the current state is RUN or MEM_WAIT and pc_write_o=0. It saturates at 2^CNT_W-1. IDLE and FAULT cycles are not counted.
- A reset asserted mid-stall returns everything to reset values immediately, with no edge needed.

Test Plan:
- Reset then start_i pulse: state_o 0→1, all writes=1, stall_cnt_o=0. Before start, pc_write_o=0 and idex_bubble_o=1.
- Load-use on rs2: ex_memread_i=1, ex_rd=5, id_rs2=5, id_uses_rs2_i=1 for one cycle → pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for one cycle, stall_cnt_o=1. Repeat with ex_rd=0 → no stall.
- Branch taken with a concurrent load-use hazard → ifid_flush_o=0 and stall asserted. Next cycle, hazard cleared and branch_taken_i=1 → ifid_flush_o=1, pc_write_o=1.
- mem_req_i=1 and ack after 3 cycles → state MEM_WAIT for 3 cycles with writes=0 and memwb_bubble_o=1, back to RUN, stall_cnt_o=+4. Same-cycle req+ack → no stall.
- TMO_CYC=4, no ack → FAULT after 4 wait cycles, fault_o=1 held. rst_i pulse mid-FAULT → state_o=0, fault_o=0 asynchronously.
- CNT_W=3 with 10 stalled cycles → stall_cnt_o saturates at 7.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, register-stage controls out.
// master = the controller, slave = the datapath/pipeline side.
`timescale 1ns/1ps
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  // Sequencing and hazard-detection inputs to the controller
  logic             start_i;
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_uses_rs2_i;
  logic             ex_memread_i;
  logic [4:0]       ex_rd_addr_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ack_i;

  // Pipeline-register controls and status from the controller
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_write_o;
  logic             idex_bubble_o;
  logic             exmem_write_o;
  logic             memwb_bubble_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             fault_o;

  modport master (
    input  start_i, id_rs1_addr_i, id_rs2_addr_i, id_uses_rs2_i,
           ex_memread_i, ex_rd_addr_i, branch_taken_i, mem_req_i, mem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
           idex_bubble_o, exmem_write_o, memwb_bubble_o, state_o,
           stall_cnt_o, fault_o
  );

  modport slave (
    output start_i, id_rs1_addr_i, id_rs2_addr_i, id_uses_rs2_i,
           ex_memread_i, ex_rd_addr_i, branch_taken_i, mem_req_i, mem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
           idex_bubble_o, exmem_write_o, memwb_bubble_o, state_o,
           stall_cnt_o, fault_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline controller: drives stage write-enables, flushes
// and bubbles; resolves load-use stalls, ID branch flushes and data-memory
// waits, with a sticky FAULT state when a memory wait times out.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TMO_CYC = 255,
  parameter int unsigned TMO_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_i,
  pipe_hazard_ctrl_if.master      bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_CYC);

  state_e           state_q;
  state_e           state_d;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;
  logic [CNT_W-1:0] stall_q;
  logic             fault_q;

  logic             mem_stall;
  logic             load_use;
  logic             stall_inc;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_bubble;
  logic             exmem_write;
  logic             memwb_bubble;

  // Hazard detection on the current ID/EX contents
  always_comb begin
    mem_stall = bus.mem_req_i & ~bus.mem_ack_i;
    load_use  = bus.ex_memread_i
              & (bus.ex_rd_addr_i != '0)
              & ((bus.id_rs1_addr_i == bus.ex_rd_addr_i)
                 | (bus.id_uses_rs2_i & (bus.id_rs2_addr_i == bus.ex_rd_addr_i)));
  end

  // Output decode and next-state/timeout logic from registered state and inputs
  always_comb begin
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_write   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b0;
    memwb_bubble = 1'b0;
    state_d      = state_q;
    tmo_d        = tmo_q;

    unique case (state_q)
      ST_IDLE: begin
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
        if (bus.start_i) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        if (mem_stall) begin
          // Memory wait dominates: freeze everything up to EX/MEM
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
          state_d      = ST_MEM_WAIT;
          tmo_d        = TMO_W'(1);
        end else if (load_use) begin
          // Hold PC and IF/ID, inject a bubble behind the load
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (bus.branch_taken_i) begin
          ifid_flush = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        memwb_bubble = 1'b1;
        if (bus.mem_ack_i) begin
          state_d = ST_RUN;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LIMIT) begin
          state_d = ST_FAULT;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_FAULT: begin
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
      end

      default: begin
        idex_bubble  = 1'b1;
        memwb_bubble = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // Stall cycles are only counted while the pipeline is live
  always_comb begin
    stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_write;
  end

  // State, timeout counter, saturating stall counter and sticky fault flag
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      stall_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (state_d == ST_FAULT) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign bus.pc_write_o     = pc_write;
  assign bus.ifid_write_o   = ifid_write;
  assign bus.ifid_flush_o   = ifid_flush;
  assign bus.idex_write_o   = idex_write;
  assign bus.idex_bubble_o  = idex_bubble;
  assign bus.exmem_write_o  = exmem_write;
  assign bus.memwb_bubble_o = memwb_bubble;
  assign bus.state_o        = state_q;
  assign bus.stall_cnt_o    = stall_q;
  assign bus.fault_o        = fault_q;

endmodule
